// File: rtl/instr_fetch_queue_if.sv
// Instruction-memory read port between the fetch queue (master) and memory (slave).
// One request is accepted per mem_req & mem_ready; data returns later on mem_rvalid.
interface instr_fetch_queue_if #(
    parameter int unsigned n  = 32,
    parameter int unsigned DW = 32
);
    logic          mem_req;
    logic [n-1:0]  mem_addr;
    logic          mem_ready;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ready,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ready,
        output mem_rvalid,
        output mem_rdata
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// Fetch stage: issues one instruction read at a time from the current PC and buffers
// returned words with their PCs in a DEPTH-entry FIFO for decode.
module instr_fetch_queue #(
    parameter int unsigned n     = 32,
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [n-1:0]             pc_in,
    output logic                     pc_inc,
    input  logic                     flush,
    instr_fetch_queue_if.master      mem,
    output logic                     inst_valid,
    output logic [DW-1:0]            inst_out,
    output logic [n-1:0]             inst_pc,
    input  logic                     inst_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] Full = CW'(DEPTH);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDrop} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   wptr_q, rptr_q;
    logic [CW-1:0]   count_q, count_upd;
    logic [n-1:0]    req_pc_q;
    logic [DW-1:0]   data_mem [DEPTH];
    logic [n-1:0]    pc_mem   [DEPTH];
    logic            accept, push, pop;

    assign push      = (state_q == StWait) & mem.mem_rvalid & ~flush;
    assign pop       = inst_valid & inst_ready;
    // Occupancy after this cycle's push/pop, ignoring flush.
    assign count_upd = count_q + CW'(push) - CW'(pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (count_q < Full && !flush) state_d = StReq;
            StReq: begin
                if (flush) begin
                    state_d = StIdle;
                end else if (accept) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (mem.mem_rvalid) begin
                    state_d = (flush || count_upd == Full) ? StIdle : StReq;
                end else if (flush) begin
                    state_d = StDrop;
                end
            end
            StDrop: if (mem.mem_rvalid) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem.mem_req  = (state_q == StReq) & ~flush;
        mem.mem_addr = pc_in;
        accept       = mem.mem_req & mem.mem_ready;
        pc_inc       = accept;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            req_pc_q <= '0;
        end else begin
            if (accept) begin
                req_pc_q <= pc_in;
            end
            if (flush) begin
                wptr_q  <= '0;
                rptr_q  <= '0;
                count_q <= '0;
            end else begin
                if (push) wptr_q <= wptr_q + 1'b1;
                if (pop)  rptr_q <= rptr_q + 1'b1;
                count_q <= count_upd;
            end
        end
    end

    // Storage needs no reset: the head is masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            data_mem[wptr_q] <= mem.mem_rdata;
            pc_mem[wptr_q]   <= req_pc_q;
        end
    end

    always_comb begin
        inst_valid = (count_q != '0);
        inst_out   = inst_valid ? data_mem[rptr_q] : '0;
        inst_pc    = inst_valid ? pc_mem[rptr_q] : '0;
        count      = count_q;
    end

endmodule
